// File: rtl/sum_buf_pkg.sv
// Shared defaults, types and occupancy encoding for the sum stream buffer.
// Optional parity storage is selected by the SUM_BUF_PARITY_EN macro in the users of this package.
package sum_buf_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_CNT_W = 8;

   typedef logic [DEF_WIDTH-1:0]       data_t;
   typedef logic [$clog2(DEF_DEPTH)-1:0] ptr_t;
   typedef logic [$clog2(DEF_DEPTH):0]   level_t;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

endpackage

// File: rtl/sum_stream_buffer_if.sv
// Producer/consumer bundle of the sum stream buffer; slave = buffer, master = its environment.
// With SUM_BUF_PARITY_EN defined the bundle also carries out_par.
interface sum_stream_buffer_if import sum_buf_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // ready and valid driven by the buffer depend only on its registered state.
   logic                     in_valid;
   logic [WIDTH-1:0]         in_data;
   logic                     in_ready;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_data;
   logic                     out_ready;
   logic [$clog2(DEPTH):0]   level;
   logic [CNT_W-1:0]         drop_cnt;
`ifdef SUM_BUF_PARITY_EN
   logic                     out_par;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, level, drop_cnt, out_par
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, level, drop_cnt, out_par
   );
`else
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, level, drop_cnt
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, level, drop_cnt
   );
`endif

endinterface

// File: rtl/sum_buf_mem.sv
// Storage array of the sum stream buffer: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module sum_buf_mem #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sum_stream_buffer.sv
// FWFT FIFO behind the registered adder: captures sums, drops and counts them when full.
// Define SUM_BUF_PARITY_EN to store an even-parity bit per entry and drive out_par.
module sum_stream_buffer import sum_buf_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   sum_stream_buffer_if.slave  bus,
   output occ_e                occ_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
`ifdef SUM_BUF_PARITY_EN
   localparam int ENTRY_W = WIDTH + 1;
`else
   localparam int ENTRY_W = WIDTH;
`endif

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   occ_e             occ_q, occ_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             push, pop, drop;
   logic [ENTRY_W-1:0] wr_entry, rd_entry;

   always_comb begin
      push = bus.in_valid && in_ready_q;
      pop  = out_valid_q && bus.out_ready;
      drop = bus.in_valid && !in_ready_q;

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end

      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end

      occ_d = occ_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (push) occ_d = OCC_PARTIAL;
         end
         OCC_PARTIAL: begin
            if (push && !pop && (level_q == LVL_W'(DEPTH - 1))) begin
               occ_d = OCC_FULL;
            end else if (pop && !push && (level_q == LVL_W'(1))) begin
               occ_d = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (pop) occ_d = OCC_PARTIAL;
         end
         default: occ_d = OCC_EMPTY;
      endcase

      // Handshake flags are registered from the next level so they never see in_valid/out_ready.
      in_ready_d  = (level_d != LVL_W'(DEPTH));
      out_valid_d = (level_d != LVL_W'(0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         drop_cnt_q  <= '0;
         occ_q       <= OCC_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         drop_cnt_q  <= drop_cnt_d;
         occ_q       <= occ_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef SUM_BUF_PARITY_EN
   assign wr_entry = {^bus.in_data, bus.in_data};
`else
   assign wr_entry = bus.in_data;
`endif

   sum_buf_mem #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push && !rst),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = rd_entry[WIDTH-1:0];
   assign bus.level     = level_q;
   assign bus.drop_cnt  = drop_cnt_q;
`ifdef SUM_BUF_PARITY_EN
   assign bus.out_par   = rd_entry[WIDTH];
`endif
   assign occ_state     = occ_q;

endmodule

// File: tb/tb_sum_stream_buffer.sv
// Directed bench for sum_stream_buffer (DEPTH=4, WIDTH=8, CNT_W=8); parity checks under SUM_BUF_PARITY_EN.
module tb_sum_stream_buffer;
   import sum_buf_pkg::*;

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] din;
      logic       ordy;
      logic       ov;
      logic [7:0] dout;
      logic       ir;
      logic [2:0] lvl;
      logic [7:0] drop;
   } vec_t;

   logic clk;
   logic rst;
   occ_e occ;
   int   n_cmp;
   int   n_err;
   logic [7:0] exp_q[$];
   vec_t tbl[$];

   sum_stream_buffer_if #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) bus ();

   sum_stream_buffer #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .occ_state (occ)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
      rst           = r;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
   endtask

   function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] d, input logic ordy,
                               input logic ov, input logic [7:0] dout, input logic ir,
                               input logic [2:0] lvl, input logic [7:0] drop);
      vec_t v;
      v.rst = r; v.iv = iv; v.din = d; v.ordy = ordy;
      v.ov = ov; v.dout = dout; v.ir = ir; v.lvl = lvl; v.drop = drop;
      return v;
   endfunction

   function automatic occ_e occ_of(input logic [2:0] lvl);
      if (lvl == 3'd0) return OCC_EMPTY;
      if (lvl == 3'd4) return OCC_FULL;
      return OCC_PARTIAL;
   endfunction

   task automatic push_data(input logic [7:0] d);
      drive(1'b0, 1'b1, d, 1'b0);
      step();
      exp_q.push_back(d);
   endtask

`ifdef SUM_BUF_PARITY_EN
   always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
         chk("parity_invariant", {31'd0, ^bus.out_data ^ bus.out_par}, 32'd0);
      end
   end
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      // rst iv din ordy | ov dout ir lvl drop  (state after the edge)
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h03, 0, 1, 8'h03, 1, 1, 0));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 8'h00, 1, 1, 0));
      tbl.push_back(mk(0, 1, 8'h03, 0, 1, 8'h00, 1, 2, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 8'h00, 1, 3, 0));
      tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 8'h00, 0, 4, 0));
      tbl.push_back(mk(0, 1, 8'h11, 0, 1, 8'h00, 0, 4, 1));
      tbl.push_back(mk(0, 1, 8'h22, 1, 1, 8'h03, 1, 3, 2));
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h00, 1, 2, 2));
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'hFF, 1, 1, 2));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 2));
      tbl.push_back(mk(0, 1, 8'h55, 1, 1, 8'h55, 1, 1, 2));
      tbl.push_back(mk(0, 1, 8'h66, 1, 1, 8'h66, 1, 1, 2));
      tbl.push_back(mk(1, 1, 8'h77, 1, 0, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].iv, tbl[i].din, tbl[i].ordy);
         step();
         chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ov});
         chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].ir});
         chk($sformatf("v%0d_level", i), {29'd0, bus.level}, {29'd0, tbl[i].lvl});
         chk($sformatf("v%0d_drop_cnt", i), {24'd0, bus.drop_cnt}, {24'd0, tbl[i].drop});
         chk($sformatf("v%0d_occ", i), {30'd0, occ}, {30'd0, occ_of(tbl[i].lvl)});
         if (tbl[i].ov) begin
            chk($sformatf("v%0d_out_data", i), {24'd0, bus.out_data}, {24'd0, tbl[i].dout});
         end
      end

      // wrap-around: hold level 2 while pushing and popping every cycle
      push_data(8'hA0);
      push_data(8'hA1);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("wrap%0d_out_data", i), {24'd0, bus.out_data}, {24'd0, exp_q[0]});
         drive(1'b0, 1'b1, 8'hA2 + 8'(i), 1'b1);
         step();
         void'(exp_q.pop_front());
         exp_q.push_back(8'hA2 + 8'(i));
         chk($sformatf("wrap%0d_level", i), {29'd0, bus.level}, 32'd2);
      end
      while (exp_q.size() > 0) begin
         chk("wrap_drain_out_data", {24'd0, bus.out_data}, {24'd0, exp_q[0]});
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         step();
         void'(exp_q.pop_front());
      end
      chk("wrap_drain_valid", {31'd0, bus.out_valid}, 32'd0);

      // saturation of the drop counter while full
      for (int i = 0; i < 4; i++) push_data(8'(8'h30 + i));
      chk("sat_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      for (int i = 0; i < 300; i++) begin
         drive(1'b0, 1'b1, 8'hEE, 1'b0);
         step();
         if (i == 0)   chk("sat_first_drop", {24'd0, bus.drop_cnt}, 32'd1);
         if (i == 253) chk("sat_254", {24'd0, bus.drop_cnt}, 32'd254);
         if (i == 254) chk("sat_255", {24'd0, bus.drop_cnt}, 32'd255);
      end
      chk("sat_hold", {24'd0, bus.drop_cnt}, 32'd255);
      chk("sat_level", {29'd0, bus.level}, 32'd4);
      chk("sat_head", {24'd0, bus.out_data}, 32'h30);
      drive(1'b1, 1'b1, 8'hEE, 1'b1);
      step();
      chk("sat_rst_drop", {24'd0, bus.drop_cnt}, 32'd0);
      chk("sat_rst_level", {29'd0, bus.level}, 32'd0);
      chk("sat_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("sat_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      exp_q.delete();

`ifdef SUM_BUF_PARITY_EN
      push_data(8'h07);
      chk("par_07", {31'd0, bus.out_par}, 32'd1);
      drive(1'b0, 1'b1, 8'h03, 1'b1);
      step();
      chk("par_03_data", {24'd0, bus.out_data}, 32'h03);
      chk("par_03", {31'd0, bus.out_par}, 32'd0);
`endif

      drive(1'b0, 1'b0, 8'h00, 1'b0);
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
